bmem_resp: RTL and testbench

Memory-side responder for the multicycle CPU's memory strobes. It accepts single-cycle `memrd`/`memwr` requests, along with the address from the MAR and write data from the MDR, issued by the control FSM. It services each request against an internal synchronous array after a configurable number of wait states. It then returns a one-cycle `ack` with read data, and flags protocol errors (conflicting strobes, out-of-range address, overrun).

---
 rtl/bmem_resp.sv | 167 ++++++++++++++++
 tb/tb_bmem_resp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bmem_resp.sv
// bmem_resp: memory-side responder for the multicycle CPU's memrd/memwr strobes.
// A request is accepted only in IDLE, waits WAIT_CYCLES cycles, then completes
// with a one-cycle ack. Rejected requests (conflicting strobes, out-of-range
// address, protected write) take the same path but never touch the array, and
// they pulse err together with ack.
// Optional feature macro: BMEM_WRPROT_EN, which rejects writes below PROT_TOP.
module bmem_resp #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned PROT_TOP    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memrd,
    input  logic              memwr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err,
    output logic              ovr
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef BMEM_WRPROT_EN
    localparam bit WRPROT = 1'b1;
`else
    localparam bit WRPROT = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic              rej_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ovr_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              req;
    logic              req_wr;
    logic              req_rej;
    logic              accept;
    logic              acc_wr;
    logic              acc_rej;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              resp_entry;
    logic              mem_we;
    logic              mem_re;

    // Request decode, next state, and the operation that commits on RESP entry
    always_comb begin
        req       = memrd | memwr;
        req_wr    = memwr & ~memrd;
        req_rej   = (memrd & memwr)
                  | (32'(addr) >= DEPTH)
                  | (WRPROT & req_wr & (32'(addr) < PROT_TOP));
        accept    = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        // By default the access uses the latched request
        acc_wr    = wr_q;
        acc_rej   = rej_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    accept = 1'b1;
                    // With zero wait states the access happens on the accept edge,
                    // so it must use the live request instead of the latched one.
                    acc_wr    = req_wr;
                    acc_rej   = req_rej;
                    acc_addr  = addr;
                    acc_wdata = wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase

        resp_entry = (state_d == StResp) && (state_q != StResp);
        mem_we     = resp_entry & acc_wr & ~acc_rej;
        mem_re     = resp_entry & ~acc_wr & ~acc_rej;
    end

    // Control state, latched request, read data and sticky overrun flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rej_q   <= 1'b0;
            rdata_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                wr_q    <= req_wr;
                rej_q   <= req_rej;
            end
            if (mem_re) begin
                rdata_q <= mem[acc_addr[IDX_W-1:0]];
            end
            // Strobes outside IDLE are dropped, only remembered here
            if (req && (state_q != StIdle)) begin
                ovr_q <= 1'b1;
            end
        end
    end

    // Storage array; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_addr[IDX_W-1:0]] <= acc_wdata;
        end
    end

    // Outputs are decoded from state so reset forces them low at once
    always_comb begin
        busy  = (state_q != StIdle);
        ack   = (state_q == StResp);
        err   = (state_q == StResp) & rej_q;
        rdata = rdata_q;
        ovr   = ovr_q;
    end

endmodule

// File: tb/tb_bmem_resp.sv
// Testbench for bmem_resp: three instances (0, 1 and 2 wait states; the last
// has a reduced depth) checked against a transaction-level reference model.
module tb_bmem_resp;

    logic       clk;
    logic       reset;
    logic       memrd [3];
    logic       memwr [3];
    logic [7:0] addr  [3];
    logic [7:0] wdata [3];
    logic [7:0] rdata [3];
    logic       ack   [3];
    logic       busy  [3];
    logic       err   [3];
    logic       ovr   [3];

    int n_tests;
    int n_fail;

    // Reference model state
    logic [7:0] m_mem   [3][256];
    bit         m_val   [3][256];
    logic [7:0] m_rdata [3];
    bit         m_rv    [3];
    bit         m_ovr   [3];

`ifdef BMEM_WRPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    bmem_resp #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0), .PROT_TOP(16)) u_dut0 (
        .clk(clk), .reset(reset), .memrd(memrd[0]), .memwr(memwr[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0]),
        .ovr(ovr[0])
    );
    bmem_resp #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(1), .PROT_TOP(16)) u_dut1 (
        .clk(clk), .reset(reset), .memrd(memrd[1]), .memwr(memwr[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1]),
        .ovr(ovr[1])
    );
    bmem_resp #(.DATA_W(8), .ADDR_W(8), .DEPTH(192), .WAIT_CYCLES(2), .PROT_TOP(16)) u_dut2 (
        .clk(clk), .reset(reset), .memrd(memrd[2]), .memwr(memwr[2]), .addr(addr[2]),
        .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .busy(busy[2]), .err(err[2]),
        .ovr(ovr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int waits_of(input int k);
        return k;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 2) ? 192 : 256;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input bit rd, input bit wr, input int a, input int d);
        memrd[k] = rd;
        memwr[k] = wr;
        addr[k]  = 8'(a);
        wdata[k] = 8'(d);
    endtask

    // Outputs of instance k while idle
    task automatic check_idle(input int k, input string tag);
        check({tag, ".busy"}, 32'(busy[k]), 32'd0);
        check({tag, ".ack"},  32'(ack[k]),  32'd0);
        check({tag, ".err"},  32'(err[k]),  32'd0);
        check({tag, ".ovr"},  32'(ovr[k]),  32'(m_ovr[k]));
        if (m_rv[k]) check({tag, ".rdata"}, 32'(rdata[k]), 32'(m_rdata[k]));
    endtask

    // One request on instance k, entered and left at a falling edge.
    // inj >= 0 drives an extra read strobe during response cycle inj.
    task automatic op(input int k, input bit rd, input bit wr, input int a, input int d,
                      input int inj, input string tag);
        int  w;
        bit  rej;
        bit  pend;
        w    = waits_of(k);
        rej  = (rd && wr) || (a >= depth_of(k)) || (PROT && wr && !rd && a < 16);
        pend = 1'b0;
        drive(k, rd, wr, a, d);
        @(negedge clk);
        for (int i = 0; i <= w; i++) begin
            if (i == w && !rej) begin
                if (wr) begin
                    m_mem[k][a] = 8'(d);
                    m_val[k][a] = 1'b1;
                end else if (m_val[k][a]) begin
                    m_rdata[k] = m_mem[k][a];
                    m_rv[k]    = 1'b1;
                end else begin
                    m_rv[k] = 1'b0;
                end
            end
            check({tag, ".busy"}, 32'(busy[k]), 32'd1);
            check({tag, ".ack"},  32'(ack[k]),  32'(i == w));
            check({tag, ".err"},  32'(err[k]),  32'((i == w) && rej));
            check({tag, ".ovr"},  32'(ovr[k]),  32'(m_ovr[k]));
            if (m_rv[k]) check({tag, ".rdata"}, 32'(rdata[k]), 32'(m_rdata[k]));
            if (i == inj) begin
                drive(k, 1'b1, 1'b0, int'($urandom_range(0, 255)), 0);
                pend = 1'b1;
            end else begin
                drive(k, 1'b0, 1'b0, 0, 0);
            end
            @(negedge clk);
            if (pend) m_ovr[k] = 1'b1;
        end
        drive(k, 1'b0, 1'b0, 0, 0);
        check_idle(k, {tag, ".idle"});
    endtask

    initial begin
        int k;
        int r;
        int a;
        int d;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 1'b0, 0, 0);
            m_rdata[i] = 8'h00;
            m_rv[i]    = 1'b1;
            m_ovr[i]   = 1'b0;
            for (int j = 0; j < 256; j++) begin
                m_val[i][j] = 1'b0;
                m_mem[i][j] = 8'h00;
            end
        end

        // Reset values
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i, "reset");
        reset = 1'b1;
        @(negedge clk);

        // Write then read back
        for (int i = 0; i < 3; i++) begin
            op(i, 1'b0, 1'b1, 8'h20, 8'hA5, -1, "wr20");
            op(i, 1'b1, 1'b0, 8'h20, 0, -1, "rd20");
        end

        // Conflicting strobes on a location holding 8'h11
        for (int i = 0; i < 3; i++) begin
            op(i, 1'b0, 1'b1, 8'h30, 8'h11, -1, "wr30");
            op(i, 1'b1, 1'b1, 8'h30, 8'hEE, -1, "both30");
            op(i, 1'b1, 1'b0, 8'h30, 0, -1, "rd30");
        end

        // Out-of-range address on the reduced-depth instance
        op(2, 1'b0, 1'b1, 8'hC0, 8'h77, -1, "wr_oor");
        op(2, 1'b1, 1'b0, 8'hFF, 0, -1, "rd_oor");
        op(2, 1'b1, 1'b0, 8'hBF, 0, -1, "rd_edge");

        // Write-protection boundary (model decides whether it applies)
        op(1, 1'b0, 1'b1, 8'h05, 8'h5A, -1, "wr05");
        op(1, 1'b1, 1'b0, 8'h05, 0, -1, "rd05");
        op(1, 1'b0, 1'b1, 8'h10, 8'h5A, -1, "wr10");
        op(1, 1'b1, 1'b0, 8'h10, 0, -1, "rd10");
        op(1, 1'b0, 1'b1, 8'h0F, 8'h3C, -1, "wr0f");

        // Strobe one cycle after accept is dropped and sets sticky overrun
        op(2, 1'b1, 1'b0, 8'h20, 0, 0, "ovr2");
        op(2, 1'b0, 1'b1, 8'h21, 8'h42, -1, "after_ovr2");
        op(0, 1'b1, 1'b0, 8'h30, 0, 0, "ovr0");

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 2));
            r = int'($urandom_range(0, 9));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(160, 255))
                                             : int'($urandom_range(0, 31));
            d = int'($urandom_range(0, 255));
            if (r < 4)      op(k, 1'b0, 1'b1, a, d, -1, "rnd_wr");
            else if (r < 8) op(k, 1'b1, 1'b0, a, 0, -1, "rnd_rd");
            else if (r < 9) op(k, 1'b1, 1'b1, a, d, -1, "rnd_both");
            else            op(k, 1'b0, 1'b1, a, d, waits_of(k), "rnd_inj");
        end

        // Asynchronous reset during the wait of a write
        op(2, 1'b0, 1'b1, 8'h40, 8'h00, -1, "wr40_init");
        drive(2, 1'b0, 1'b1, 8'h40, 8'hFF);
        @(negedge clk);
        drive(2, 1'b0, 1'b0, 0, 0);
        check("pre_reset.busy", 32'(busy[2]), 32'd1);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            m_ovr[i]   = 1'b0;
            m_rdata[i] = 8'h00;
            m_rv[i]    = 1'b1;
            check_idle(i, "async_reset");
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        op(2, 1'b1, 1'b0, 8'h40, 0, -1, "rd40");
        op(1, 1'b1, 1'b0, 8'h20, 0, -1, "rd20_post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
